// File: rtl/icache_fill_ctrl.sv
// Direct-mapped read-only instruction cache with a single-outstanding line fill FSM.
// Hits return in the lookup cycle; misses stall IF while one 4-word line is fetched.
module icache_fill_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_re,
    input  logic [15:0]      fetch_addr,
    input  logic             inv_all,
    output logic [15:0]      instr,
    output logic             instr_vld,
    output logic             stall,
    output logic             mem_re,
    output logic [13:0]      mem_addr,
    input  logic [63:0]      mem_rdata,
    input  logic             mem_rdy,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int SETS  = 1 << INDEX_BITS;
    localparam int TAG_W = 14 - INDEX_BITS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [SETS-1:0]        valid_q, valid_d;
    logic [13:0]            miss_line_q, miss_line_d;
    logic                   kill_fill_q, kill_fill_d;
    logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]       tag_q  [SETS];
    logic [63:0]            data_q [SETS];

    logic [INDEX_BITS-1:0]  fetch_idx;
    logic [TAG_W-1:0]       fetch_tag;
    logic [INDEX_BITS-1:0]  fill_idx;
    logic [TAG_W-1:0]       fill_tag;
    logic [63:0]            line_sel;
    logic                   hit;
    logic                   fill_we;

    assign fetch_idx = fetch_addr[2 +: INDEX_BITS];
    assign fetch_tag = fetch_addr[15 -: TAG_W];
    assign fill_idx  = miss_line_q[0 +: INDEX_BITS];
    assign fill_tag  = miss_line_q[13 -: TAG_W];

    // Lookup only counts as a hit in IDLE, so the arrays are never read mid-fill.
    assign hit       = (state_q == ST_IDLE) && valid_q[fetch_idx] &&
                       (tag_q[fetch_idx] == fetch_tag);
    assign line_sel  = data_q[fetch_idx];
    assign instr     = line_sel[{fetch_addr[1:0], 4'b0000} +: 16];
    assign instr_vld = fetch_re & hit;
    assign stall     = fetch_re & ~instr_vld;

    assign mem_re    = (state_q == ST_WAIT);
    assign mem_addr  = miss_line_q;
    assign fill_we   = (state_q == ST_WAIT) && mem_rdy;

    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

    always_comb begin
        state_d     = state_q;
        miss_line_d = miss_line_q;
        kill_fill_d = kill_fill_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        if (instr_vld && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                kill_fill_d = 1'b0;
                if (fetch_re && !hit) begin
                    miss_line_d = fetch_addr[15:2];
                    state_d     = ST_WAIT;
                    if (miss_cnt_q != {CNT_W{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // An invalidate while the line is in flight must not let it become valid.
                if (inv_all) begin
                    kill_fill_d = 1'b1;
                end
                if (mem_rdy) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (inv_all) begin
            valid_d = '0;
        end else if (fill_we && !kill_fill_q) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            miss_line_q <= '0;
            kill_fill_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_line_q <= miss_line_d;
            kill_fill_q <= kill_fill_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[fill_idx] <= mem_rdata;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

endmodule
